// File: rtl/arith_pkg.sv
// Shared ALU arithmetic definitions.
// Common to the mul and div units.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic TYPE_UNSIGNED = 1'b0;
    localparam logic TYPE_SIGNED   = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Trial subtract of the divisor from the shifted partial remainder.
module div_step #(
    parameter int N_BIT = 4
) (
    input  logic [N_BIT:0]   rem_sh,
    input  logic [N_BIT-1:0] dvs,
    output logic [N_BIT-1:0] rem_next,
    output logic             q_bit
);

    logic [N_BIT:0] trial;

    // Partial remainder stays below the divisor, so a restored or
    // reduced value always fits back into N_BIT bits.
    assign trial    = rem_sh - {1'b0, dvs};
    assign q_bit    = ~trial[N_BIT];
    assign rem_next = q_bit ? trial[N_BIT-1:0] : rem_sh[N_BIT-1:0];

endmodule

// File: rtl/div.sv
// Iterative restoring divider, one quotient bit per clock.
// Signed or unsigned per operation; fixed N_BIT+2 cycle latency.
module div
    import arith_pkg::*;
#(
    parameter int N_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] A,
    input  logic [N_BIT-1:0] B,
    input  logic             div_type,
    output logic             busy,
    output logic             done,
    output logic [N_BIT-1:0] quotient,
    output logic [N_BIT-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(N_BIT + 1);

    state_t state, state_nx;

    logic [N_BIT-1:0] rem, quo, dvs, a_raw;
    logic [N_BIT-1:0] a_mag, b_mag, rem_nx;
    logic [N_BIT:0]   rem_sh;
    logic [CW-1:0]    cnt;
    logic             s_a, s_b, dz;
    logic             sa_in, sb_in, q_bit;
    logic             accept, last;
    logic             busy_nx, done_nx;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(N_BIT - 1));
    assign sa_in  = (div_type == TYPE_SIGNED) && A[N_BIT-1];
    assign sb_in  = (div_type == TYPE_SIGNED) && B[N_BIT-1];
    assign a_mag  = sa_in ? -A : A;
    assign b_mag  = sb_in ? -B : B;
    assign rem_sh = {rem, quo[N_BIT-1]};

    div_step #(
        .N_BIT    (N_BIT)
    ) u_step (
        .rem_sh   (rem_sh),
        .dvs      (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: if (last)  state_nx = FIX;
            FIX:             state_nx = DONE;
            DONE: state_nx = start ? CALC : IDLE;
        endcase
    end

    always_comb begin
        busy_nx = (state_nx == CALC) || (state_nx == FIX);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            a_raw       <= '0;
            s_a         <= 1'b0;
            s_b         <= 1'b0;
            dz          <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            a_raw <= A;
            s_a   <= sa_in;
            s_b   <= sb_in;
            dz    <= (B == '0);
            cnt   <= '0;
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= {quo[N_BIT-2:0], q_bit};
            cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
            div_by_zero <= dz;
            if (dz) begin
                quotient  <= '1;
                remainder <= a_raw;
            end else begin
                quotient  <= (s_a ^ s_b) ? -quo : quo;
                remainder <= s_a ? -rem : rem;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (N_BIT=4).
// Directed scenarios plus exhaustive and random sweeps vs. integer model.
module tb_div;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       div_type;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks;
    int n_fail;

    div #(.N_BIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .div_type    (div_type),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer-arithmetic reference: truncating division, remainder
    // with dividend sign, all-ones quotient on zero divisor.
    function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                    input logic t, output logic [3:0] q,
                                    output logic [3:0] r, output logic z);
        int ai, bi, qi, ri;
        ai = t ? int'($signed(a)) : int'(a);
        bi = t ? int'($signed(b)) : int'(b);
        if (bi == 0) begin
            q = 4'hF;
            r = a;
            z = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[3:0];
            r  = ri[3:0];
            z  = 1'b0;
        end
    endfunction

    // Drives one start; returns in the done cycle (lat=-1 on timeout).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic t, output int lat, output int nbusy);
        A        = a;
        B        = b;
        div_type = t;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        div_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b q=%b r=%b dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, nb;
        @(negedge clk);
        run_op(4'b1101, 4'b0011, 1'b0, lat, nb);
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL u13_3_latency: got %0d, want 6", lat);
        end
        n_checks++;
        if (nb !== 5) begin
            n_fail++;
            $display("FAIL u13_3_busy_cycles: got %0d, want 5", nb);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {4'b0100, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL u13_3_result: got q=%b r=%b dz=%b, want q=0100 r=0001 dz=0",
                     quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 4'b0100, 4'b0001}) begin
            n_fail++;
            $display("FAIL u13_3_hold: got done=%b busy=%b q=%b r=%b, want 0 0 0100 0001",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_signed();
        int lat, nb;
        @(negedge clk);
        run_op(4'b1001, 4'b0010, 1'b1, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, 4'b1101, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL s_m7_2: got lat=%0d q=%b r=%b dz=%b, want 6 1101 1111 0",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        run_op(4'b1001, 4'b0010, 1'b0, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, 4'b0100, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL u9_2: got lat=%0d q=%b r=%b dz=%b, want 6 0100 0001 0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_overflow();
        int lat, nb;
        @(negedge clk);
        run_op(4'b1000, 4'b1111, 1'b1, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, 4'b1000, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL s_m8_m1: got lat=%0d q=%b r=%b dz=%b, want 6 1000 0000 0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, nb;
        @(negedge clk);
        run_op(4'b1001, 4'b0000, 1'b0, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, 4'b1111, 4'b1001, 1'b1}) begin
            n_fail++;
            $display("FAIL u9_0: got lat=%0d q=%b r=%b dz=%b, want 6 1111 1001 1",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        run_op(4'b1101, 4'b0000, 1'b1, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, 4'b1111, 4'b1101, 1'b1}) begin
            n_fail++;
            $display("FAIL s_m3_0: got lat=%0d q=%b r=%b dz=%b, want 6 1111 1101 1",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        A = 4'b1101;
        B = 4'b0011;
        div_type = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) begin
                A = 4'b0111;
                B = 4'b0001;
                div_type = 1'b1;
                start = 1'b1;
            end else if (c == 4) begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if ({lat == 6, quotient, remainder} !== {1'b1, 4'b0100, 4'b0001}) begin
            n_fail++;
            $display("FAIL ignore_start: got lat=%0d q=%b r=%b, want 6 0100 0001",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        logic [3:0] eq, er;
        logic ez;
        @(negedge clk);
        run_op(4'b0111, 4'b0010, 1'b0, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder} !== {1'b1, 4'b0011, 4'b0001}) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d q=%b r=%b, want 6 0011 0001",
                     lat, quotient, remainder);
        end
        run_op(4'b1010, 4'b0011, 1'b1, lat, nb);
        ref_div(4'b1010, 4'b0011, 1'b1, eq, er, ez);
        n_checks++;
        if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, eq, er, ez}) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d q=%b r=%b dz=%b, want 6 %b %b %b",
                     lat, quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, seen;
        @(negedge clk);
        A = 4'b1111;
        B = 4'b0010;
        div_type = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b q=%b r=%b dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: got %0d active cycles, want 0", seen);
        end
        @(negedge clk);
        run_op(4'b1111, 4'b0010, 1'b0, lat, nb);
        n_checks++;
        if ({lat == 6, quotient, remainder} !== {1'b1, 4'b0111, 4'b0001}) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got lat=%0d q=%b r=%b, want 6 0111 0001",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_sweep();
        int lat, nb;
        logic [3:0] a, b, eq, er;
        logic t, ez;
        @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            t = k[8];
            a = k[7:4];
            b = k[3:0];
            run_op(a, b, t, lat, nb);
            ref_div(a, b, t, eq, er, ez);
            n_checks++;
            if ({lat == 6, quotient, remainder, div_by_zero} !== {1'b1, eq, er, ez}) begin
                n_fail++;
                $display("FAIL sweep t=%b a=%b b=%b: got lat=%0d q=%b r=%b dz=%b, want 6 %b %b %b",
                         t, a, b, lat, quotient, remainder, div_by_zero, eq, er, ez);
            end
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
            end
        end
        for (int k = 0; k < 64; k++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            t = 1'($urandom);
            run_op(a, b, t, lat, nb);
            ref_div(a, b, t, eq, er, ez);
            n_checks++;
            if ({lat == 6, nb == 5, quotient, remainder, div_by_zero} !== {2'b11, eq, er, ez}) begin
                n_fail++;
                $display("FAIL random t=%b a=%b b=%b: got lat=%0d busy=%0d q=%b r=%b dz=%b, want 6 5 %b %b %b",
                         t, a, b, lat, nb, quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Iterative restoring divider: the inverse of the array multiplier. Computes quotient and remainder of two N_BIT operands, signed or unsigned, selected per operation by `div_type`. Retires one quotient bit per clock under a start/done handshake. Sits beside `mul` in the ALU and shares its operand width and signed/unsigned select semantics.

## Interface
- `N_BIT`, default 4: operand, quotient and remainder width.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request; sampled only in IDLE or DONE.
- `A`, input, N_BIT: dividend; sampled with `start`.
- `B`, input, N_BIT: divisor; sampled with `start`.
- `div_type`, input, 1: 0 = unsigned, 1 = two's-complement signed; sampled with `start`.
- `busy`, output, 1: high in CALC and FIX.
- `done`, output, 1: high for exactly one cycle, in DONE.
- `quotient`, output, N_BIT: result; holds until the next accepted start completes.
- `remainder`, output, N_BIT: result; holds until the next accepted start completes.
- `div_by_zero`, output, 1: flag for the last completed operation; valid with and after `done`.

## Operation
- States:
  - IDLE: start -> CALC, else stay.
  - CALC: runs N_BIT cycles, then -> FIX.
  - FIX: 1 cycle, then -> DONE.
  - DONE: start -> CALC, else -> IDLE.
- Accept, on the start edge:
  - Latch the magnitudes |A| and |B| when `div_type`=1 and the operand MSB is 1; latch raw values otherwise.
  - Latch sA, sB (0 when unsigned) and the zero-divisor flag.
  - Clear the (N_BIT+1)-bit partial remainder.
  - Load the quotient shift register with the dividend magnitude.
  - Clear the iteration counter ($clog2(N_BIT+1) bits).
- Each CALC cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − {1'b0, divisor}.
  - If trial is non-negative: rem ← trial and quo[0] ← 1. Otherwise keep rem and set quo[0] ← 0.
- FIX:
  - Quotient: negate if sA^sB; remainder: negate if sA. Truncation is toward zero; the remainder takes the dividend's sign.
  - Write `quotient`, `remainder` and `div_by_zero`.
- Divide by zero: `quotient` = all ones and `remainder` = A (raw bits), for both types. `quotient` is forced in FIX. Latency is unchanged.
- Signed overflow (most-negative / −1): `quotient` = most-negative, `remainder` = 0, `div_by_zero` = 0. This results from the magnitude path with no special case.
- `start` in CALC or FIX is ignored; operand changes during CALC or FIX have no effect.
- `rst_n` low at any time, including mid-CALC: state IDLE immediately, all outputs and internal registers 0. The aborted operation produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- Start accepted at edge 0.
- CALC occupies the cycles after edges 0..N_BIT−1; FIX follows edge N_BIT.
- Results are registered at edge N_BIT+1; `done` is high in the cycle after edge N_BIT+1.
- Fixed latency: `done` follows the accepting edge by N_BIT+2 cycles (6 for N_BIT=4), independent of operands.
- Back-to-back: `start` during the DONE cycle is accepted. Throughput is one result per N_BIT+2 cycles.
- `busy`, `done` and all results are register outputs; there is no combinational path from any input.

## Structure
- Shared package `arith_pkg` holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the `div_type`/`mul_type` encodings (TYPE_UNSIGNED=0, TYPE_SIGNED=1), common to `mul` and `div`.
- Sub-module `div_step`: combinational single iteration. It takes the shifted remainder and divisor and returns the next remainder and the quotient bit. Instantiated once and reused every CALC cycle.

## Test plan
- Unsigned 13/3 (A=1101, B=0011, div_type=0) -> quotient 0100, remainder 0001, div_by_zero 0, `done` 6 cycles after the start edge, `busy` high for 5 cycles.
- Signed −7/2 (A=1001, B=0010) -> quotient 1101 (−3), remainder 1111 (−1). Same bits as unsigned 9/2 -> quotient 0100, remainder 0001.
- Signed −8/−1 (A=1000, B=1111) -> quotient 1000, remainder 0000, div_by_zero 0.
- Divide by zero:
  - unsigned 9/0 -> quotient 1111, remainder 1001, div_by_zero 1;
  - signed −3/0 (A=1101) -> quotient 1111, remainder 1101, div_by_zero 1.
- Handshake:
  - `start` with new operands mid-CALC is ignored and the original result is returned;
  - `start` in the DONE cycle gives the next `done` exactly 6 cycles later;
  - `rst_n` pulsed low at CALC cycle 2 -> all outputs 0, no `done`, and the next start completes normally.
- Random sweep: all 256 operand pairs for both div_type values, checked against a reference model (truncating quotient, dividend-signed remainder, zero-divisor rule).
